alu_multicycle: RTL

//  Parametrised WIDTH-bit ALU that evaluates SLICE bits per clock and ripples the carry between slices

---
 rtl/alu_multicycle.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Brief    : WIDTH-bit ALU evaluated SLICE bits per clock, carry rippled
//            between slices through a register (AND/OR/ADD/SUB/SLT + flags).
// Revision : 1.0
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int c_N     = WIDTH / SLICE;
    localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    generate
        if (WIDTH % SLICE != 0) begin : g_slice_check
            $error("alu_multicycle: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic               w_accept;
    logic               w_finish;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_work;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;

    logic [SLICE-1:0]   w_a_sl;
    logic [SLICE-1:0]   w_b_sl;
    logic [SLICE:0]     w_sum;
    logic [SLICE-1:0]   w_slice_res;
    logic               w_cin_msb;
    logic [WIDTH-1:0]   w_work_next;
    logic [WIDTH-1:0]   w_final;
    logic               w_cout_final;
    logic               w_ovf_final;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_RUN;
                end
            end
            default: begin
                if (r_cnt == c_LAST) begin
                    w_finish     = 1'b1;
                    w_state_next = c_IDLE;
                end
            end
        endcase
    end

    // One slice of the datapath; B is inverted for SUB/SLT (Binvert)
    always_comb begin
        w_a_sl      = r_a[32'(r_cnt) * SLICE +: SLICE];
        w_b_sl      = r_op[2] ? ~r_b[32'(r_cnt) * SLICE +: SLICE]
                              :  r_b[32'(r_cnt) * SLICE +: SLICE];
        w_sum       = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (SLICE+1)'(r_carry);
        w_cin_msb   = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sum[SLICE-1];
        case (r_op[1:0])
            2'b00:   w_slice_res = w_a_sl & w_b_sl;
            2'b01:   w_slice_res = w_a_sl | w_b_sl;
            default: w_slice_res = w_sum[SLICE-1:0];
        endcase
        w_work_next = r_work;
        w_work_next[32'(r_cnt) * SLICE +: SLICE] = w_slice_res;
    end

    // Final result/flags; only meaningful on the last slice
    always_comb begin
        w_final      = '0;
        w_cout_final = 1'b0;
        w_ovf_final  = 1'b0;
        case (r_op)
            3'b000, 3'b001: w_final = w_work_next;
            3'b010, 3'b110: begin
                w_final      = w_work_next;
                w_cout_final = w_sum[SLICE];
                w_ovf_final  = w_cin_msb ^ w_sum[SLICE];
            end
            3'b111: begin
                w_final      = {{(WIDTH-1){1'b0}},
                                w_work_next[WIDTH-1] ^ w_cin_msb ^ w_sum[SLICE]};
                w_cout_final = w_sum[SLICE];
                w_ovf_final  = w_cin_msb ^ w_sum[SLICE];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_work      <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_finish;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_op    <= op;
                r_cnt   <= '0;
                r_carry <= op[2];
            end else if (r_state == c_RUN) begin
                r_work  <= w_work_next;
                r_carry <= w_sum[SLICE];
                if (w_finish) begin
                    r_result    <= w_final;
                    r_carry_out <= w_cout_final;
                    r_overflow  <= w_ovf_final;
                    r_zero      <= (w_final == '0);
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign busy      = (r_state == c_RUN);
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire
